// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Upstream (MEM -> WB) result bus for the write-back stage.
//
// Signals
//   in_valid        MEM result valid (driven by master)
//   in_ready        WB stage accepts input this cycle (driven by slave)
//   in_rd           destination register
//   in_rd_wen       instruction writes rd
//   in_wb_sel       result source: 00 ALU, 01 load, 10 PC+4, 11 ALU
//   in_alu_res      ALU result
//   in_pc           instruction PC
//   in_mem_rdata    raw aligned memory word
//   in_mem_size     00 byte, 01 half, 10/11 word
//   in_mem_unsigned zero-extend a loaded byte or half
//   in_addr_lo      load address bits [1:0]
//
// Modports
//   master : the MEM stage side
//   slave  : the WB stage side
// -----------------------------------------------------------------------------
interface wb_stage_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_rd_wen;
   logic [1:0]            in_wb_sel;
   logic [DATA_WIDTH-1:0] in_alu_res;
   logic [DATA_WIDTH-1:0] in_pc;
   logic [DATA_WIDTH-1:0] in_mem_rdata;
   logic [1:0]            in_mem_size;
   logic                  in_mem_unsigned;
   logic [1:0]            in_addr_lo;

   modport master (
      output in_valid,
      output in_rd,
      output in_rd_wen,
      output in_wb_sel,
      output in_alu_res,
      output in_pc,
      output in_mem_rdata,
      output in_mem_size,
      output in_mem_unsigned,
      output in_addr_lo,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_rd,
      input  in_rd_wen,
      input  in_wb_sel,
      input  in_alu_res,
      input  in_pc,
      input  in_mem_rdata,
      input  in_mem_size,
      input  in_mem_unsigned,
      input  in_addr_lo,
      output in_ready
   );
endinterface

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back pipeline stage: a one-entry stage register that takes a result
// from the MEM stage, selects/extracts the value to write, drives the register
// file write port and the decode forwarding bypass, flags misaligned loads and
// counts retired instructions.
//
// Ports
//   clk           single clock, all state updates on posedge
//   rst           synchronous active-low reset
//   up            upstream bus (wb_stage_if.slave)
//   halt          debug stall: hold entry, block writes and captures
//   flush         discard held and incoming instruction (overrides halt)
//   wen/waddr/wdata           register file write port
//   fwd_valid/fwd_rd/fwd_data forwarding bypass to decode
//   misalign_err  held load is misaligned
//   instret       64-bit retired-instruction counter
//
// The written value is computed when the instruction is captured and stored
// in the stage register, so waddr/wdata come straight from flops.  While rst
// is low the stage presents itself as empty, so a held entry is never written
// in the reset cycle.
// -----------------------------------------------------------------------------
module wb_stage #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   wb_stage_if.slave             up,
   input  logic                  halt,
   input  logic                  flush,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  fwd_valid,
   output logic [ADDR_WIDTH-1:0] fwd_rd,
   output logic [DATA_WIDTH-1:0] fwd_data,
   output logic                  misalign_err,
   output logic [63:0]           instret
);

   localparam logic [1:0] SEL_ALU   = 2'b00;
   localparam logic [1:0] SEL_LOAD  = 2'b01;
   localparam logic [1:0] SEL_PC4   = 2'b10;
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);

   // Extract a byte/half/word from the aligned memory word, with sign or zero
   // extension of sub-word values.
   function automatic logic [DATA_WIDTH-1:0] load_extract(
      input logic [DATA_WIDTH-1:0] rdata,
      input logic [1:0]            size,
      input logic                  uns,
      input logic [1:0]            addr_lo
   );
      logic [7:0]            byte_v;
      logic [15:0]           half_v;
      logic [DATA_WIDTH-1:0] res_v;
      byte_v = rdata[{addr_lo, 3'b000} +: 8];
      half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
      case (size)
         SIZE_BYTE: res_v = {{(DATA_WIDTH-8){byte_v[7] & ~uns}}, byte_v};
         SIZE_HALF: res_v = {{(DATA_WIDTH-16){half_v[15] & ~uns}}, half_v};
         default:   res_v = rdata;
      endcase
      return res_v;
   endfunction

   // A load is misaligned when a half sits on an odd byte or a word is not
   // on a 4-byte boundary; size 11 behaves as a word.
   function automatic logic load_misaligned(
      input logic [1:0] sel,
      input logic [1:0] size,
      input logic [1:0] addr_lo
   );
      logic mis_v;
      if (sel != SEL_LOAD) begin
         mis_v = 1'b0;
      end else begin
         case (size)
            SIZE_BYTE: mis_v = 1'b0;
            SIZE_HALF: mis_v = addr_lo[0];
            default:   mis_v = (addr_lo != 2'b00);
         endcase
      end
      return mis_v;
   endfunction

   // Choose the value to write back; select 11 behaves as ALU.
   function automatic logic [DATA_WIDTH-1:0] select_result(
      input logic [1:0]            sel,
      input logic [DATA_WIDTH-1:0] alu_res,
      input logic [DATA_WIDTH-1:0] pc,
      input logic [DATA_WIDTH-1:0] load_val
   );
      logic [DATA_WIDTH-1:0] res_v;
      case (sel)
         SEL_ALU:  res_v = alu_res;
         SEL_LOAD: res_v = load_val;
         SEL_PC4:  res_v = pc + PC_STEP;
         default:  res_v = alu_res;
      endcase
      return res_v;
   endfunction

   // Stage register
   logic                  wb_valid_r;
   logic [ADDR_WIDTH-1:0] rd_r;
   logic                  rd_wen_r;
   logic [DATA_WIDTH-1:0] result_r;
   logic                  misalign_r;
   logic [63:0]           instret_r;

   // Combinational control
   logic                  valid_s;
   logic                  capture_s;
   logic                  retire_s;
   logic                  write_ok_s;
   logic                  wb_valid_nxt_s;
   logic [DATA_WIDTH-1:0] load_val_s;
   logic [DATA_WIDTH-1:0] result_nxt_s;
   logic                  misalign_nxt_s;

   // Handshake, retire decision and next-entry value computation.
   always_comb begin
      up.in_ready    = ~halt;
      valid_s        = wb_valid_r & rst;
      capture_s      = up.in_valid & ~halt & ~flush;
      retire_s       = valid_s & ~halt & ~flush;
      write_ok_s     = rd_wen_r & (rd_r != {ADDR_WIDTH{1'b0}}) & ~misalign_r;
      load_val_s     = load_extract(up.in_mem_rdata, up.in_mem_size,
                                    up.in_mem_unsigned, up.in_addr_lo);
      result_nxt_s   = select_result(up.in_wb_sel, up.in_alu_res, up.in_pc,
                                     load_val_s);
      misalign_nxt_s = load_misaligned(up.in_wb_sel, up.in_mem_size,
                                       up.in_addr_lo);
      // Flush wins, a capture replaces a retiring entry, otherwise hold.
      if (flush) begin
         wb_valid_nxt_s = 1'b0;
      end else if (capture_s) begin
         wb_valid_nxt_s = 1'b1;
      end else if (retire_s) begin
         wb_valid_nxt_s = 1'b0;
      end else begin
         wb_valid_nxt_s = wb_valid_r;
      end
   end

   // Stage register and retire counter update.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_valid_r <= 1'b0;
         rd_r       <= {ADDR_WIDTH{1'b0}};
         rd_wen_r   <= 1'b0;
         result_r   <= {DATA_WIDTH{1'b0}};
         misalign_r <= 1'b0;
         instret_r  <= 64'd0;
      end else begin
         wb_valid_r <= wb_valid_nxt_s;
         if (capture_s) begin
            rd_r       <= up.in_rd;
            rd_wen_r   <= up.in_rd_wen;
            result_r   <= result_nxt_s;
            misalign_r <= misalign_nxt_s;
         end
         // Natural 64-bit wrap on overflow.
         if (retire_s) begin
            instret_r <= instret_r + 64'd1;
         end
      end
   end

   // Write port, bypass and error outputs; forced quiet while in reset.
   always_comb begin
      wen          = 1'b0;
      waddr        = {ADDR_WIDTH{1'b0}};
      wdata        = {DATA_WIDTH{1'b0}};
      fwd_valid    = 1'b0;
      fwd_rd       = {ADDR_WIDTH{1'b0}};
      fwd_data     = {DATA_WIDTH{1'b0}};
      misalign_err = 1'b0;
      instret      = instret_r;
      if (rst) begin
         wen          = retire_s & write_ok_s;
         waddr        = rd_r;
         wdata        = result_r;
         // Bypass stays live during halt so decode can keep forwarding.
         fwd_valid    = valid_s & write_ok_s;
         fwd_rd       = rd_r;
         fwd_data     = result_r;
         misalign_err = valid_s & misalign_r;
      end else begin
         wen          = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model of the stage (one held entry and a retire count).
// -----------------------------------------------------------------------------
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        halt;
   logic        flush;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        misalign_err;
   logic [63:0] instret;

   int total;
   int bad;

   wb_stage_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .up           (bus),
      .halt         (halt),
      .flush        (flush),
      .wen          (wen),
      .waddr        (waddr),
      .wdata        (wdata),
      .fwd_valid    (fwd_valid),
      .fwd_rd       (fwd_rd),
      .fwd_data     (fwd_data),
      .misalign_err (misalign_err),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: the entry currently held and the retire count.
   typedef struct {
      bit        v;
      bit [4:0]  rd;
      bit        rdw;
      bit [31:0] res;
      bit        mis;
   } ent_t;

   ent_t      held;
   bit [63:0] m_inst;
   bit        post_rst;

   function automatic bit [31:0] exp_res(bit [1:0] sel, bit [31:0] alu, bit [31:0] pc,
                                         bit [31:0] rdata, bit [1:0] size, bit uns,
                                         bit [1:0] alo);
      bit [31:0] v;
      if (sel == 2'd2) return pc + 32'd4;
      if (sel != 2'd1) return alu;
      if (size == 2'd0) begin
         v = (rdata >> (int'(alo) * 8)) & 32'hFF;
         if (!uns && v >= 32'h80) v = v - 32'h100;
         return v;
      end
      if (size == 2'd1) begin
         v = (rdata >> (int'(alo[1]) * 16)) & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v - 32'h10000;
         return v;
      end
      return rdata;
   endfunction

   function automatic bit exp_mis(bit [1:0] sel, bit [1:0] size, bit [1:0] alo);
      if (sel != 2'd1) return 1'b0;
      if (size == 2'd1) return (alo % 2) == 1;
      if (size >= 2'd2) return alo != 2'd0;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model for the inputs currently applied.
   task automatic check_all();
      bit ev, ok;
      ev = held.v && rst;
      ok = held.rdw && (held.rd != 5'd0) && !held.mis;
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !halt});
      chk("wen", {63'd0, wen}, {63'd0, ev && !halt && !flush && ok});
      chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, ev && ok});
      chk("misalign_err", {63'd0, misalign_err}, {63'd0, ev && held.mis});
      chk("instret", instret, m_inst);
      if (!rst || post_rst) begin
         chk("waddr_rst", {59'd0, waddr}, 64'd0);
         chk("wdata_rst", {32'd0, wdata}, 64'd0);
      end else if (ev) begin
         chk("waddr", {59'd0, waddr}, {59'd0, held.rd});
         chk("wdata", {32'd0, wdata}, {32'd0, held.res});
         chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, held.rd});
         chk("fwd_data", {32'd0, fwd_data}, {32'd0, held.res});
      end
   endtask

   // Advance the model across the coming posedge.
   task automatic model_update();
      bit retire;
      if (!rst) begin
         held     = '{default: 0};
         m_inst   = 64'd0;
         post_rst = 1'b1;
      end else begin
         retire = held.v && !halt && !flush;
         if (retire) m_inst = m_inst + 64'd1;
         if (flush) begin
            held.v = 1'b0;
         end else if (bus.in_valid && !halt) begin
            held.v   = 1'b1;
            held.rd  = bus.in_rd;
            held.rdw = bus.in_rd_wen;
            held.res = exp_res(bus.in_wb_sel, bus.in_alu_res, bus.in_pc, bus.in_mem_rdata,
                               bus.in_mem_size, bus.in_mem_unsigned, bus.in_addr_lo);
            held.mis = exp_mis(bus.in_wb_sel, bus.in_mem_size, bus.in_addr_lo);
            post_rst = 1'b0;
         end else if (retire) begin
            held.v = 1'b0;
         end
      end
   endtask

   task automatic settle();
      #4;
      check_all();
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst                 = 1'b1;
      halt                = 1'b0;
      flush               = 1'b0;
      bus.in_valid        = 1'b0;
      bus.in_rd           = 5'd0;
      bus.in_rd_wen       = 1'b0;
      bus.in_wb_sel       = 2'd0;
      bus.in_alu_res      = 32'd0;
      bus.in_pc           = 32'd0;
      bus.in_mem_rdata    = 32'd0;
      bus.in_mem_size     = 2'd0;
      bus.in_mem_unsigned = 1'b0;
      bus.in_addr_lo      = 2'd0;
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
      bus.in_valid   = 1'b1;
      bus.in_rd      = rd;
      bus.in_rd_wen  = 1'b1;
      bus.in_wb_sel  = 2'd0;
      bus.in_alu_res = val;
   endtask

   task automatic ld(input logic [4:0] rd, input logic [31:0] rdata, input logic [1:0] size,
                     input logic uns, input logic [1:0] alo);
      bus.in_valid        = 1'b1;
      bus.in_rd           = rd;
      bus.in_rd_wen       = 1'b1;
      bus.in_wb_sel       = 2'd1;
      bus.in_mem_rdata    = rdata;
      bus.in_mem_size     = size;
      bus.in_mem_unsigned = uns;
      bus.in_addr_lo      = alo;
   endtask

   // Capture one instruction already set on the bus, then show it with idle inputs.
   task automatic capture_then_idle();
      settle();
      tick();
      idle();
      settle();
   endtask

   initial begin
      logic [63:0] cnt;
      total = 0;
      bad   = 0;

      // Initial reset: DUT state is unknown before the first edge.
      idle();
      rst      = 1'b0;
      held     = '{default: 0};
      m_inst   = 64'd0;
      post_rst = 1'b1;
      @(posedge clk);
      #1;
      settle();
      tick();
      idle();
      settle();
      chk("reset_wen", {63'd0, wen}, 64'd0);
      chk("reset_instret", instret, 64'd0);
      chk("reset_wdata", {32'd0, wdata}, 64'd0);
      tick();

      // ALU op writes one cycle after acceptance.
      alu_op(5'd5, 32'h1234);
      capture_then_idle();
      chk("alu_wen", {63'd0, wen}, 64'd1);
      chk("alu_waddr", {59'd0, waddr}, 64'd5);
      chk("alu_wdata", {32'd0, wdata}, 64'h1234);
      tick();
      chk("alu_instret", instret, 64'd1);

      // Load extraction.
      idle();
      ld(5'd3, 32'h80FF7F01, 2'd0, 1'b0, 2'd3);
      capture_then_idle();
      chk("lb_signed", {32'd0, wdata}, 64'hFFFFFF80);
      tick();
      ld(5'd3, 32'h80FF7F01, 2'd0, 1'b1, 2'd3);
      capture_then_idle();
      chk("lb_unsigned", {32'd0, wdata}, 64'h00000080);
      tick();
      ld(5'd3, 32'h80FF7F01, 2'd1, 1'b0, 2'd2);
      capture_then_idle();
      chk("lh_signed", {32'd0, wdata}, 64'hFFFF80FF);
      tick();

      // Misaligned half: no write, no forward, still retires.
      ld(5'd4, 32'h12345678, 2'd1, 1'b0, 2'd1);
      capture_then_idle();
      chk("mis_err", {63'd0, misalign_err}, 64'd1);
      chk("mis_wen", {63'd0, wen}, 64'd0);
      chk("mis_fwd", {63'd0, fwd_valid}, 64'd0);
      cnt = instret;
      tick();
      chk("mis_instret", instret, cnt + 64'd1);

      // PC+4 with wrap, to x0 and to x1.
      bus.in_valid = 1'b1; bus.in_rd = 5'd0; bus.in_rd_wen = 1'b1;
      bus.in_wb_sel = 2'd2; bus.in_pc = 32'hFFFFFFFC;
      capture_then_idle();
      chk("x0_wen", {63'd0, wen}, 64'd0);
      chk("x0_fwd", {63'd0, fwd_valid}, 64'd0);
      chk("x0_wdata", {32'd0, wdata}, 64'd0);
      tick();
      bus.in_valid = 1'b1; bus.in_rd = 5'd1; bus.in_rd_wen = 1'b1;
      bus.in_wb_sel = 2'd2; bus.in_pc = 32'hFFFFFFFC;
      capture_then_idle();
      chk("x1_wen", {63'd0, wen}, 64'd1);
      chk("x1_wdata", {32'd0, wdata}, 64'd0);
      tick();

      // Halt holds the entry for 3 cycles, ignoring new input.
      alu_op(5'd7, 32'hCAFEF00D);
      settle();
      tick();
      cnt = instret;
      for (int i = 0; i < 3; i++) begin
         idle();
         halt = 1'b1;
         alu_op(5'd9, 32'h1111);
         settle();
         chk("halt_wen", {63'd0, wen}, 64'd0);
         chk("halt_ready", {63'd0, bus.in_ready}, 64'd0);
         chk("halt_fwd", {63'd0, fwd_valid}, 64'd1);
         chk("halt_instret", instret, cnt);
         tick();
      end
      idle();
      settle();
      chk("release_wen", {63'd0, wen}, 64'd1);
      chk("release_wdata", {32'd0, wdata}, 64'hCAFEF00D);
      tick();
      chk("release_instret", instret, cnt + 64'd1);

      // Flush during halt discards the held entry.
      alu_op(5'd8, 32'h55);
      settle();
      tick();
      idle(); halt = 1'b1;
      settle();
      tick();
      idle(); halt = 1'b1; flush = 1'b1;
      settle();
      chk("flush_wen", {63'd0, wen}, 64'd0);
      cnt = instret;
      tick();
      idle();
      settle();
      chk("flush_fwd", {63'd0, fwd_valid}, 64'd0);
      chk("flush_instret", instret, cnt);
      tick();

      // Back-to-back stream after a reset.
      idle(); rst = 1'b0;
      settle();
      tick();
      for (int k = 0; k < 4; k++) begin
         idle();
         alu_op(5'(k + 1), 32'(k * 256 + 3));
         settle();
         if (k > 0) chk("stream_wen", {63'd0, wen}, 64'd1);
         tick();
      end
      idle();
      settle();
      chk("stream_last_wen", {63'd0, wen}, 64'd1);
      chk("stream_last_waddr", {59'd0, waddr}, 64'd4);
      tick();
      chk("stream_instret", instret, 64'd4);

      // Reset in the middle of a stream.
      alu_op(5'd10, 32'hA);
      settle();
      tick();
      alu_op(5'd11, 32'hB);
      settle();
      tick();
      idle(); rst = 1'b0;
      settle();
      tick();
      idle();
      settle();
      chk("midrst_wen", {63'd0, wen}, 64'd0);
      chk("midrst_instret", instret, 64'd0);
      tick();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         rst                 = ($urandom_range(0, 39) != 0);
         halt                = ($urandom_range(0, 5) == 0);
         flush               = ($urandom_range(0, 9) == 0);
         bus.in_valid        = ($urandom_range(0, 3) != 0);
         bus.in_rd           = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         bus.in_rd_wen       = ($urandom_range(0, 4) != 0);
         bus.in_wb_sel       = 2'($urandom_range(0, 3));
         bus.in_alu_res      = $urandom;
         bus.in_pc           = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
         bus.in_mem_rdata    = $urandom;
         bus.in_mem_size     = 2'($urandom_range(0, 3));
         bus.in_mem_unsigned = 1'($urandom_range(0, 1));
         bus.in_addr_lo      = 2'($urandom_range(0, 3));
         settle();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
